mux8_valve_sequencer: RTL and testbench
=======================================

Name: mux8_valve_sequencer

Overview:
- Electronic controller that drives the six pneumatic control lines of the 8:1 valve multiplexer (lines c1..c6) feeding the logic array.
- Accepts one routing request at a time: input index plus dwell time.
- Runs a break-before-make sequence: open the selected path, hold it for the dwell, close all valves, then report completion.
- Guarantees that no two inputs are ever connected and that every valve is closed at idle and during reset.

Parameters:
T_ACT, 8, valve actuation/settle time in clock cycles for both OPEN and CLOSE phases; legal range is 1..255.
DWELL_W, 16, width of the requested dwell count.
CLOSED_LEVEL, 1, logic level on a control line that pressurises (closes) a valve; open is the inverse.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  high only in IDLE; a request is accepted on any rising edge where req_valid && req_ready.
req_sel  input  3  input index 0..7, mapping to mux inputs i1..i8.
req_dwell  input  DWELL_W  FLOW phase length in cycles; 0 is legal.
abort  input  1  ends the current routing early.
valve_ctrl  output  6  control lines; bit0..bit5 drive c1..c6.
flow_active  output  1  high in the FLOW state.
busy  output  1  high when not in IDLE.
done  output  1  one-cycle pulse when a sequence completes.
aborted  output  1  valid with done; high if the sequence was cut short by abort.
cur_sel  output  3  captured req_sel; holds its value until the next accept.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - valve_ctrl = all bits CLOSED_LEVEL.
  - req_ready=1; busy=0, flow_active=0, done=0, aborted=0, cur_sel=0.
  - Reset asserted mid-sequence closes all valves in the same cycle; no done pulse is produced.
- All outputs are registered.
- States and transitions:
  - IDLE: all valves closed. On accept: capture req_sel and req_dwell, go to OPEN.
  - OPEN: lasts exactly T_ACT cycles, driving the path pattern. Then go to FLOW if dwell>0, otherwise CLOSE.
  - FLOW: lasts exactly dwell cycles, same pattern. flow_active=1. Then go to CLOSE.
  - CLOSE: all valves closed for exactly T_ACT cycles. Then go to IDLE, asserting done=1 and req_ready=1 in the first IDLE cycle.
- Path pattern for index k (only these three lines are open; the other three are CLOSED_LEVEL):
  - c1 open if k[0]=0, else c2.
  - c3 open if k[1]=0, else c4.
  - c5 open if k[2]=0, else c6.
- Invariant: at most one of each pair {c1,c2}, {c3,c4}, {c5,c6} is open in any cycle. Outside OPEN/FLOW, none is open.
- Timing, with accept at cycle 0:
  - OPEN: cycles 1..T_ACT.
  - FLOW: cycles T_ACT+1..T_ACT+D.
  - CLOSE: cycles T_ACT+D+1..2*T_ACT+D.
  - done: cycle 2*T_ACT+D+1.
  - Earliest next accept is that same cycle, so back-to-back requests always have all valves closed for at least T_ACT cycles between them.
- Abort:
  - Sampled in OPEN or FLOW: the next cycle enters CLOSE with the full T_ACT closing time. The sticky aborted flag is reported with done.
  - Ignored in IDLE and CLOSE. Abort together with an accept in IDLE: the accept proceeds and the abort is ignored.
- req_sel, req_dwell and req_valid changing while busy have no effect. A held req_valid is accepted again in the done cycle.
- Counters:
  - Phase counter is 8 bits; dwell counter is DWELL_W bits.
  - Both are loaded on phase entry and counted down, with no wrap.
  - Maximum dwell is 2^DWELL_W-1.
- aborted clears on the next accept.

Test Plan:
1. Reset, then T_ACT=4, accept sel=0, dwell=3 -> valve_ctrl=6'b101010 (c1,c3,c5 open, with CLOSED_LEVEL=1) for cycles 1..7; flow_active in cycles 5..7; 6'b111111 in cycles 8..11; done=1, aborted=0 in cycle 12.
2. sel=7, dwell=0 -> pattern 6'b010101 for cycles 1..4, never flow_active, closed in cycles 5..8, done in cycle 9.
3. sel=5, dwell=100, abort pulsed in cycle 10 -> closed from cycle 11 for 4 cycles, done with aborted=1 in cycle 15.
4. req_valid held high with sel alternating 2 then 6 -> second accept lands in the done cycle; valves are all closed for ≥4 cycles between patterns; no pair is ever both open (bench checks the invariant every cycle).
5. rst asserted asynchronously during FLOW -> valve_ctrl=6'b111111 before the next clock edge; busy=0; no done pulse; the next request sequences normally.
6. abort asserted during IDLE and during CLOSE -> no effect on timing; aborted=0 at done.

Source files
------------

// File: rtl/mux8_valve_sequencer.sv
// mux8_valve_sequencer
// Drives the six pneumatic control lines (c1..c6) of an 8:1 valve multiplexer.
// Each request runs a break-before-make sequence:
//   OPEN (T_ACT cycles) -> FLOW (dwell cycles) -> CLOSE (T_ACT cycles) -> IDLE.
// Every output is a flop. All flops load from the next-state logic, so the
// outputs always match the state they describe.
module mux8_valve_sequencer #(
  parameter int   T_ACT        = 8,
  parameter int   DWELL_W      = 16,
  parameter logic CLOSED_LEVEL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_sel,
  input  logic [DWELL_W-1:0] req_dwell,
  input  logic               abort,
  output logic [5:0]         valve_ctrl,
  output logic               flow_active,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [2:0]         cur_sel
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OPEN  = 2'd1;
  localparam logic [1:0] S_FLOW  = 2'd2;
  localparam logic [1:0] S_CLOSE = 2'd3;

  // Counters are loaded with length-1 and a phase ends when the counter reads zero.
  localparam logic [7:0]         PHASE_LOAD = 8'(T_ACT - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = 1;
  localparam logic [5:0]         ALL_CLOSED = {6{CLOSED_LEVEL}};

  logic [1:0]         state_q, state_d;
  logic [7:0]         phase_q, phase_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [2:0]         cur_sel_q, cur_sel_d;
  logic               aborted_q, aborted_d;
  logic [5:0]         valve_ctrl_q, valve_ctrl_d;
  logic               flow_active_q, flow_active_d;
  logic               busy_q, busy_d;
  logic               req_ready_q, req_ready_d;
  logic               done_q, done_d;

  logic [5:0] open_mask;
  logic [5:0] path_ctrl;

  // Each select bit opens exactly one valve of its pair, so no pair can open together.
  for (genvar gi = 0; gi < 3; gi++) begin : g_pair
    assign open_mask[2*gi]   = ~cur_sel_d[gi];
    assign open_mask[2*gi+1] =  cur_sel_d[gi];
  end

  // An open bit flips its line away from the closed level. All other lines stay closed.
  assign path_ctrl = open_mask ^ ALL_CLOSED;

  // Sequencer next-state logic and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    dwell_d   = dwell_q;
    cur_sel_d = cur_sel_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // An abort in the same cycle as an accept is ignored.
        if (req_valid) begin
          state_d   = S_OPEN;
          phase_d   = PHASE_LOAD;
          dwell_d   = req_dwell;
          cur_sel_d = req_sel;
          aborted_d = 1'b0;
        end
      end
      S_OPEN: begin
        if (abort) begin
          state_d   = S_CLOSE;
          phase_d   = PHASE_LOAD;
          aborted_d = 1'b1;
        end else if (phase_q == 8'd0) begin
          if (dwell_q == '0) begin
            state_d = S_CLOSE;
            phase_d = PHASE_LOAD;
          end else begin
            state_d = S_FLOW;
            dwell_d = dwell_q - DWELL_ONE;
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
      S_FLOW: begin
        if (abort) begin
          state_d   = S_CLOSE;
          phase_d   = PHASE_LOAD;
          aborted_d = 1'b1;
        end else if (dwell_q == '0) begin
          state_d = S_CLOSE;
          phase_d = PHASE_LOAD;
        end else begin
          dwell_d = dwell_q - DWELL_ONE;
        end
      end
      default: begin
        // CLOSE: the full closing time always elapses. Abort has no effect here.
        if (phase_q == 8'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
    endcase

    valve_ctrl_d  = ((state_d == S_OPEN) || (state_d == S_FLOW)) ? path_ctrl : ALL_CLOSED;
    flow_active_d = (state_d == S_FLOW);
    busy_d        = (state_d != S_IDLE);
    req_ready_d   = (state_d == S_IDLE);
  end

  // State and output registers. Reset closes every valve at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      phase_q       <= 8'd0;
      dwell_q       <= '0;
      cur_sel_q     <= 3'd0;
      aborted_q     <= 1'b0;
      valve_ctrl_q  <= ALL_CLOSED;
      flow_active_q <= 1'b0;
      busy_q        <= 1'b0;
      req_ready_q   <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      dwell_q       <= dwell_d;
      cur_sel_q     <= cur_sel_d;
      aborted_q     <= aborted_d;
      valve_ctrl_q  <= valve_ctrl_d;
      flow_active_q <= flow_active_d;
      busy_q        <= busy_d;
      req_ready_q   <= req_ready_d;
      done_q        <= done_d;
    end
  end

  assign valve_ctrl  = valve_ctrl_q;
  assign flow_active = flow_active_q;
  assign busy        = busy_q;
  assign req_ready   = req_ready_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign cur_sel     = cur_sel_q;

endmodule

// File: tb/tb_mux8_valve_sequencer.sv
// Directed bench for mux8_valve_sequencer, built with T_ACT=4 and closed level 1.
module tb_mux8_valve_sequencer;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_sel = 3'd0;
  logic [15:0] req_dwell = 16'd0;
  logic        abort = 1'b0;
  logic [5:0]  valve_ctrl;
  logic        flow_active;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [2:0]  cur_sel;

  int total = 0;
  int bad   = 0;

  logic [5:0] pat [8];

  mux8_valve_sequencer #(
    .T_ACT(T),
    .DWELL_W(16),
    .CLOSED_LEVEL(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_sel(req_sel),
    .req_dwell(req_dwell),
    .abort(abort),
    .valve_ctrl(valve_ctrl),
    .flow_active(flow_active),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .cur_sel(cur_sel)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // On every cycle, no valve pair may be open at the same time, and all valves must be closed while idle.
  always @(negedge clk) begin
    if (!rst) begin
      check_val("pair_inv",
                {31'd0, (~valve_ctrl[0] & ~valve_ctrl[1]) |
                        (~valve_ctrl[2] & ~valve_ctrl[3]) |
                        (~valve_ctrl[4] & ~valve_ctrl[5])}, 32'd0);
      if (!busy) check_val("idle_closed", {26'd0, valve_ctrl}, 32'h3f);
    end
  end

  // Runs one request and checks every cycle through to the done pulse. The task
  // starts in an idle or done cycle and returns while still in the done cycle.
  task automatic run_seq(input string tag, input logic [2:0] sel, input logic [15:0] dwell,
                         input int ab_cyc, input bit ab_at_accept,
                         input bit keep, input logic [2:0] nsel);
    int  cs;
    int  dn;
    bit  ab_taken;
    ab_taken = (ab_cyc >= 1) && (ab_cyc <= T + int'(dwell));
    cs = ab_taken ? ab_cyc + 1 : T + int'(dwell) + 1;
    dn = cs + T;
    req_valid = 1'b1;
    req_sel   = sel;
    req_dwell = dwell;
    abort     = ab_at_accept;
    step();
    abort = 1'b0;
    req_dwell = ~dwell;
    if (keep) req_sel = nsel;
    else begin
      req_valid = 1'b0;
      req_sel   = ~sel;
    end
    for (int c = 1; c <= dn; c++) begin
      abort = (c == ab_cyc);
      if (c < cs) begin
        check_val({tag, "_valve_open"}, {26'd0, valve_ctrl}, {26'd0, pat[sel]});
        check_val({tag, "_flow"}, {31'd0, flow_active}, {31'd0, c > T});
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check_val({tag, "_done_early"}, {31'd0, done}, 32'd0);
      end else if (c < dn) begin
        check_val({tag, "_valve_close"}, {26'd0, valve_ctrl}, 32'h3f);
        check_val({tag, "_flow_close"}, {31'd0, flow_active}, 32'd0);
        check_val({tag, "_ready_close"}, {31'd0, req_ready}, 32'd0);
        check_val({tag, "_done_early"}, {31'd0, done}, 32'd0);
      end else begin
        check_val({tag, "_done"}, {31'd0, done}, 32'd1);
        check_val({tag, "_aborted"}, {31'd0, aborted}, {31'd0, ab_taken});
        check_val({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        check_val({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_cur_sel"}, {29'd0, cur_sel}, {29'd0, sel});
      end
      if (c < dn) step();
    end
    abort = 1'b0;
    $display("seq %s: sel=%0d dwell=%0d done_cycle=%0d aborted=%0b", tag, sel, dwell, dn, aborted);
  endtask

  initial begin
    pat[0] = 6'b101010; pat[1] = 6'b101001; pat[2] = 6'b100110; pat[3] = 6'b100101;
    pat[4] = 6'b011010; pat[5] = 6'b011001; pat[6] = 6'b010110; pat[7] = 6'b010101;

    // Reset values while reset is held.
    step();
    step();
    check_val("rst_valve", {26'd0, valve_ctrl}, 32'h3f);
    check_val("rst_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_flow", {31'd0, flow_active}, 32'd0);
    check_val("rst_aborted", {31'd0, aborted}, 32'd0);
    check_val("rst_cur_sel", {29'd0, cur_sel}, 32'd0);
    rst = 1'b0;
    step();

    // Test 1: sel 0 with dwell 3. Test 2: sel 7 with dwell 0.
    run_seq("t1", 3'd0, 16'd3, 0, 1'b0, 1'b0, 3'd0);
    step();
    run_seq("t2", 3'd7, 16'd0, 0, 1'b0, 1'b0, 3'd0);
    step();

    // Test 3: abort pulsed during FLOW.
    run_seq("t3", 3'd5, 16'd100, 10, 1'b0, 1'b0, 3'd0);
    step();

    // Test 4: req_valid held high, so the second accept lands in the done cycle.
    run_seq("t4a", 3'd2, 16'd1, 0, 1'b0, 1'b1, 3'd6);
    run_seq("t4b", 3'd6, 16'd2, 0, 1'b0, 1'b0, 3'd0);
    step();

    // Test 5: asynchronous reset asserted during FLOW.
    req_valid = 1'b1; req_sel = 3'd3; req_dwell = 16'd20;
    step();
    req_valid = 1'b0;
    for (int c = 1; c < 7; c++) step();
    check_val("t5_in_flow", {31'd0, flow_active}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("t5_async_valve", {26'd0, valve_ctrl}, 32'h3f);
    check_val("t5_async_busy", {31'd0, busy}, 32'd0);
    check_val("t5_async_ready", {31'd0, req_ready}, 32'd1);
    step();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check_val("t5_no_done", {31'd0, done}, 32'd0);
      check_val("t5_idle", {31'd0, busy}, 32'd0);
      step();
    end
    $display("seq t5: reset during flow handled");
    run_seq("t5b", 3'd4, 16'd2, 0, 1'b0, 1'b0, 3'd0);
    step();

    // Test 6: abort in IDLE, abort together with accept, and abort during CLOSE are all ignored.
    abort = 1'b1;
    step();
    step();
    check_val("t6_idle_abort_busy", {31'd0, busy}, 32'd0);
    check_val("t6_idle_abort_ready", {31'd0, req_ready}, 32'd1);
    run_seq("t6", 3'd1, 16'd2, 8, 1'b1, 1'b0, 3'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
